// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-port register file and its busy scoreboard.
package reg_file_mp_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_NUM_WR = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set by reserve at issue, cleared by write-back, reserve wins on a tie.
module rf_scoreboard
   import reg_file_mp_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter bit BYPASS   = 1'b0,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [2**ADDR_W-1:0]     wr_hit,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic                     busy_any
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] set_vec;
   logic [DEPTH-1:0] busy_d;
   logic [DEPTH-1:0] busy_q;
   logic             busy_any_q;

   always_comb begin
      set_vec = '0;
      if (rsv_en) begin
         set_vec[rsv_addr] = 1'b1;
      end
      busy_d = (busy_q & ~wr_hit) | set_vec;
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         busy_any_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         busy_any_q <= |busy_d;
      end
   end

   // Bypass only forwards a release; a fresh same-cycle reserve shows up after the edge.
   always_comb begin
      rd_busy = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         rd_busy[j] = busy_q[rd_addr[j*ADDR_W +: ADDR_W]];
         if (BYPASS && wr_hit[rd_addr[j*ADDR_W +: ADDR_W]]
                    && !set_vec[rd_addr[j*ADDR_W +: ADDR_W]]) begin
            rd_busy[j] = 1'b0;
         end
      end
   end

   assign busy_any = busy_any_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port flop-based register file with async reads, optional bypass/zero register,
// write-collision detection and a RAW busy scoreboard.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter bit BYPASS   = 1'b0,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic                     wr_conflict,
   output logic                     busy_any,
   output logic                     led
);

   localparam int DEPTH = 2**ADDR_W;

   (* syn_ramstyle = "registers" *) logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  wr_hit;
   logic              conflict_d;
   logic              conflict_q;

   // Ports are applied in ascending order so the highest enabled port wins a collision.
   always_comb begin
      mem_d  = mem_q;
      wr_hit = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_en[k]) begin
            wr_hit[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
            if (!(ZERO_REG && (wr_addr[k*ADDR_W +: ADDR_W] == '0))) begin
               mem_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Dropped writes to the zero register still collide.
   always_comb begin
      conflict_d = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (wr_en[i] && wr_en[j] &&
                (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         conflict_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         conflict_q <= conflict_d;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         rd_data[j*DATA_W +: DATA_W] = mem_q[rd_addr[j*ADDR_W +: ADDR_W]];
         if (BYPASS) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[j*ADDR_W +: ADDR_W])) begin
                  rd_data[j*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
               end
            end
         end
         if (ZERO_REG && (rd_addr[j*ADDR_W +: ADDR_W] == '0)) begin
            rd_data[j*DATA_W +: DATA_W] = '0;
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .wr_hit   (wr_hit),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy),
      .busy_any (busy_any)
   );

   assign wr_conflict = conflict_q;
   assign led         = ZERO_REG ? 1'b0 : mem_q[0][0];

endmodule
